// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg
//   Shared types and default parameter values for perf_store_monitor and
//   its sequential divider.
//   state_e : top-level run phase (WARM -> RUN -> DIV -> DONE)
//   cause_e : why a run terminated in a given RUN cycle
package perf_mon_pkg;

  localparam int DEF_XLEN         = 32;
  localparam int DEF_CNT_W        = 32;
  localparam int DEF_N_EVENTS     = 4;
  localparam int DEF_WARMUP       = 2;
  localparam int DEF_PASS_ADDR    = 100;
  localparam int DEF_PASS_DATA    = 25;
  localparam int DEF_SCRATCH_ADDR = 96;
  localparam int DEF_MAX_CYCLES   = 10000;
  localparam int DEF_FRAC_W       = 8;

  typedef enum logic [1:0] {
    WARM,
    RUN,
    DIV,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    PASS,
    FAIL,
    TIMEOUT
  } cause_e;

endpackage

// File: rtl/seq_divider.sv
// seq_divider
//   Restoring unsigned divider, one quotient bit per clock.
//   The start cycle already performs the first iteration, so a division
//   takes N_W edges including the start edge; done pulses for one cycle
//   right after the last iteration. A zero divisor returns an all-ones
//   quotient with done on the cycle after start and no iterations.
// Ports
//   clk, reset : clock, synchronous active-high reset
//   start      : load dividend/divisor (ignored while busy is expected low)
//   dividend   : N_W-bit numerator
//   divisor    : D_W-bit denominator
//   busy       : iterations still pending
//   done       : one-cycle pulse, quotient is final
//   quotient   : N_W-bit truncated quotient
module seq_divider #(
  parameter int N_W = 40,
  parameter int D_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient
);

  localparam int CNT_BITS = $clog2(N_W + 1);

  logic [D_W-1:0]      rem;
  logic [D_W-1:0]      dsr;
  logic [CNT_BITS-1:0] remaining;

  logic [D_W-1:0] src_rem;
  logic [N_W-1:0] src_q;
  logic [D_W-1:0] src_d;
  logic [D_W:0]   trial;
  logic [D_W:0]   diff;
  logic           q_bit;
  logic [D_W-1:0] rem_step;
  logic [N_W-1:0] q_step;

  // One restoring step. On the start cycle the step works on the fresh
  // operands, otherwise on the held remainder/shift register. The quotient
  // register doubles as the dividend shift register.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    src_rem  = start ? '0 : rem;
    src_q    = start ? dividend : quotient;
    src_d    = start ? divisor : dsr;
    trial    = {src_rem, src_q[N_W-1]};
    diff     = trial - {1'b0, src_d};
    q_bit    = (trial >= {1'b0, src_d});
    rem_step = q_bit ? diff[D_W-1:0] : trial[D_W-1:0];
    q_step   = {src_q[N_W-2:0], q_bit};
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem       <= '0;
      dsr       <= '0;
      remaining <= '0;
      quotient  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dsr <= divisor;
        if (divisor == '0) begin
          quotient  <= '1;
          rem       <= '0;
          remaining <= '0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end else begin
          quotient  <= q_step;
          rem       <= rem_step;
          remaining <= CNT_BITS'(N_W - 1);
          busy      <= 1'b1;
        end
      end else if (busy) begin
        quotient  <= q_step;
        rem       <= rem_step;
        remaining <= remaining - 1'b1;
        if (remaining == CNT_BITS'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/perf_store_monitor.sv
// perf_store_monitor
//   Run-completion checker and performance counters for riscvpipeline.
//   Watches memory-stage stores for the pass pair, illegal stores or a
//   cycle-budget timeout; counts cycles, retired instructions and
//   N_EVENTS pipeline events; afterwards computes fixed-point CPI.
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   MemWriteM, DataAdrM,
//   WriteDataM            : memory-stage store bus
//   RetireW               : one instruction retired this cycle
//   EventIn               : per-cycle event strobes, one per channel
//   done/pass/fail/timeout: sticky run status
//   cycle_count, instr_count, event_count : saturating counters
//   fail_addr, fail_data  : first offending store
//   cpi, cpi_valid        : Q(CNT_W-FRAC_W).FRAC_W cycles per instruction
module perf_store_monitor
  import perf_mon_pkg::*;
#(
  parameter int XLEN         = DEF_XLEN,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int N_EVENTS     = DEF_N_EVENTS,
  parameter int WARMUP       = DEF_WARMUP,
  parameter int PASS_ADDR    = DEF_PASS_ADDR,
  parameter int PASS_DATA    = DEF_PASS_DATA,
  parameter int SCRATCH_ADDR = DEF_SCRATCH_ADDR,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int FRAC_W       = DEF_FRAC_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemWriteM,
  input  logic [XLEN-1:0]           DataAdrM,
  input  logic [XLEN-1:0]           WriteDataM,
  input  logic                      RetireW,
  input  logic [N_EVENTS-1:0]       EventIn,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          instr_count,
  output logic [N_EVENTS*CNT_W-1:0] event_count,
  output logic [XLEN-1:0]           fail_addr,
  output logic [XLEN-1:0]           fail_data,
  output logic [CNT_W-1:0]          cpi,
  output logic                      cpi_valid
);

  localparam int DIV_W  = CNT_W + FRAC_W;
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

  state_e            state;
  logic [WARM_W-1:0] warm_cnt;

  logic [CNT_W-1:0] cycle_next;
  logic [CNT_W-1:0] instr_next;
  cause_e           cause;
  logic             terminal;
  logic [DIV_W-1:0] div_dividend;
  logic             div_busy;
  logic             div_done;
  logic [DIV_W-1:0] div_quotient;
  logic [CNT_W-1:0] cpi_sat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Terminal decision for the current RUN cycle. A terminal store takes
  // priority over a timeout landing on the same cycle.
  always_comb begin
    cycle_next = sat_inc(cycle_count);
    instr_next = RetireW ? sat_inc(instr_count) : instr_count;
    cause      = NONE;
    if (state == RUN) begin
      if (MemWriteM) begin
        if (DataAdrM == XLEN'(PASS_ADDR) && WriteDataM == XLEN'(PASS_DATA))
          cause = PASS;
        else if (DataAdrM != XLEN'(SCRATCH_ADDR))
          cause = FAIL;
      end
      if (cause == NONE && MAX_CYCLES != 0 &&
          64'(cycle_next) == 64'(MAX_CYCLES))
        cause = TIMEOUT;
    end
    terminal     = (cause != NONE);
    div_dividend = {cycle_next, {FRAC_W{1'b0}}};
    cpi_sat      = (|div_quotient[DIV_W-1:CNT_W]) ? '1
                                                  : div_quotient[CNT_W-1:0];
  end

  // The divider is started from the terminal cycle's final counts so that
  // its first iteration overlaps the edge that raises done.
  seq_divider #(
    .N_W (DIV_W),
    .D_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (terminal),
    .dividend (div_dividend),
    .divisor  (instr_next),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= (WARMUP == 0) ? RUN : WARM;
      warm_cnt    <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
      cpi         <= '0;
      cpi_valid   <= 1'b0;
    end else begin
      case (state)
        WARM: begin
          warm_cnt <= warm_cnt + 1'b1;
          if (warm_cnt == WARM_W'(WARMUP - 1))
            state <= RUN;
        end
        RUN: begin
          cycle_count <= cycle_next;
          instr_count <= instr_next;
          if (terminal) begin
            done    <= 1'b1;
            pass    <= (cause == PASS);
            fail    <= (cause == FAIL);
            timeout <= (cause == TIMEOUT);
            if (cause == FAIL) begin
              fail_addr <= DataAdrM;
              fail_data <= WriteDataM;
            end
            state <= DIV;
          end
        end
        DIV: begin
          if (div_done && !div_busy) begin
            cpi       <= cpi_sat;
            cpi_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= DONE;
        default: state <= state;
      endcase
    end
  end

  // Event channels only count in RUN, so they freeze with the other
  // counters once the run terminates.
  for (genvar i = 0; i < N_EVENTS; i++) begin : g_evt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (reset)
        cnt <= '0;
      else if (state == RUN && EventIn[i])
        cnt <= sat_inc(cnt);
    end
    assign event_count[i*CNT_W +: CNT_W] = cnt;
  end

endmodule
